// File: rtl/regfile_writeback_queue.sv
// rtl/regfile_writeback_queue.sv - merges ALU and load results into a FIFO that drains to the register-file write port
// Loads win arbitration; hazard flags cover queued entries plus the registered pending write.
module regfile_writeback_queue #(
  parameter int SIZE    = 16,
  parameter int REGBITS = 4,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic [REGBITS-1:0]         mem_dst,
  input  logic [SIZE-1:0]            mem_data,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [REGBITS-1:0]         alu_dst,
  input  logic [SIZE-1:0]            alu_data,
  input  logic                       wb_hold,
  output logic                       wr_en,
  output logic [REGBITS-1:0]         wr_addr,
  output logic [SIZE-1:0]            wr_data,
  input  logic [REGBITS-1:0]         qry_a,
  input  logic [REGBITS-1:0]         qry_b,
  output logic                       hazard_a,
  output logic                       hazard_b,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [REGBITS-1:0] dst_q  [DEPTH];
  logic [SIZE-1:0]    data_q [DEPTH];

  logic [PTRW-1:0]    head_q, head_d;
  logic [PTRW-1:0]    tail_q, tail_d;
  logic [CNTW-1:0]    count_q, count_d;
  logic               wr_en_q, wr_en_d;
  logic [REGBITS-1:0] wr_addr_q, wr_addr_d;
  logic [SIZE-1:0]    wr_data_q, wr_data_d;

  logic               full, empty;
  logic               enq_mem, enq_alu, enq, deq;
  logic [REGBITS-1:0] enq_dst;
  logic [SIZE-1:0]    enq_data;

  assign full  = (count_q == CNTW'(DEPTH));
  assign empty = (count_q == '0);

  // Ready never anticipates a same-cycle drain, so a full queue stalls both sources.
  assign mem_ready = !full;
  assign alu_ready = !full && !mem_valid;

  assign enq_mem  = mem_valid && mem_ready;
  assign enq_alu  = alu_valid && alu_ready;
  assign enq      = enq_mem || enq_alu;
  assign enq_dst  = enq_mem ? mem_dst  : alu_dst;
  assign enq_data = enq_mem ? mem_data : alu_data;
  assign deq      = !empty && !wb_hold;

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (enq) begin
      tail_d = tail_q + PTRW'(1);
    end
    if (deq) begin
      head_d    = head_q + PTRW'(1);
      wr_en_d   = 1'b1;
      wr_addr_d = dst_q[head_q];
      wr_data_d = data_q[head_q];
    end
    case ({enq, deq})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by head/count alone.
  always_ff @(posedge clk) begin
    if (!reset && enq) begin
      dst_q[tail_q]  <= enq_dst;
      data_q[tail_q] <= enq_data;
    end
  end

  always_comb begin
    logic [PTRW-1:0] off;
    off      = '0;
    hazard_a = wr_en_q && (wr_addr_q == qry_a);
    hazard_b = wr_en_q && (wr_addr_q == qry_b);
    for (int i = 0; i < DEPTH; i++) begin
      off = PTRW'(i) - head_q;
      if (CNTW'(off) < count_q) begin
        if (dst_q[i] == qry_a) hazard_a = 1'b1;
        if (dst_q[i] == qry_b) hazard_b = 1'b1;
      end
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign count   = count_q;

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// tb/tb_regfile_writeback_queue.sv - directed table-driven bench for regfile_writeback_queue
// Each row gives one cycle's inputs and the outputs expected during that cycle.
module tb_regfile_writeback_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid, mem_ready;
  logic [3:0]  mem_dst;
  logic [15:0] mem_data;
  logic        alu_valid, alu_ready;
  logic [3:0]  alu_dst;
  logic [15:0] alu_data;
  logic        wb_hold;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [3:0]  qry_a, qry_b;
  logic        hazard_a, hazard_b;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_writeback_queue dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dst(mem_dst), .mem_data(mem_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dst(alu_dst), .alu_data(alu_data),
    .wb_hold(wb_hold), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .qry_a(qry_a), .qry_b(qry_b), .hazard_a(hazard_a), .hazard_b(hazard_b), .count(count)
  );

  typedef struct {
    int mv; int md; int mdat;
    int av; int ad; int adat;
    int hold; int qa; int qb;
    int cnt; int mr; int ar; int ha; int hb;
    int wen; int waddr; int wdata;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input int mv, input int md, input int mdat,
                        input int av, input int ad, input int adat,
                        input int hold, input int qa, input int qb);
    mem_valid = 1'(mv);
    mem_dst   = 4'(md);
    mem_data  = 16'(mdat);
    alu_valid = 1'(av);
    alu_dst   = 4'(ad);
    alu_data  = 16'(adat);
    wb_hold   = 1'(hold);
    qry_a     = 4'(qa);
    qry_b     = 4'(qb);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    //            mv md mdat     av ad adat     hd qa qb  cnt mr ar ha hb  wen wa wdata
    vecs[0]  = '{0, 0, 0,       1, 3, 'h00A5,  0, 3, 0,  0, 1, 1, 0, 0,  0, 0, 0};
    vecs[1]  = '{0, 0, 0,       0, 0, 0,       0, 3, 0,  1, 1, 1, 1, 0,  0, 0, 0};
    vecs[2]  = '{0, 0, 0,       0, 0, 0,       0, 3, 0,  0, 1, 1, 1, 0,  1, 3, 'h00A5};
    vecs[3]  = '{0, 0, 0,       0, 0, 0,       0, 3, 0,  0, 1, 1, 0, 0,  0, 3, 'h00A5};
    vecs[4]  = '{1, 5, 'h1111,  1, 6, 'h2222,  0, 5, 6,  0, 1, 0, 0, 0,  0, 3, 'h00A5};
    vecs[5]  = '{0, 0, 0,       1, 6, 'h2222,  0, 5, 6,  1, 1, 1, 1, 0,  0, 3, 'h00A5};
    vecs[6]  = '{0, 0, 0,       0, 0, 0,       0, 5, 6,  1, 1, 1, 1, 1,  1, 5, 'h1111};
    vecs[7]  = '{0, 0, 0,       0, 0, 0,       0, 5, 6,  0, 1, 1, 0, 1,  1, 6, 'h2222};
    vecs[8]  = '{0, 0, 0,       0, 0, 0,       0, 5, 6,  0, 1, 1, 0, 0,  0, 6, 'h2222};
    vecs[9]  = '{0, 0, 0,       1, 7, 'hAAAA,  0, 7, 0,  0, 1, 1, 0, 0,  0, 6, 'h2222};
    vecs[10] = '{0, 0, 0,       1, 7, 'hBBBB,  0, 7, 0,  1, 1, 1, 1, 0,  0, 6, 'h2222};
    vecs[11] = '{0, 0, 0,       0, 0, 0,       0, 7, 0,  1, 1, 1, 1, 0,  1, 7, 'hAAAA};
    vecs[12] = '{0, 0, 0,       0, 0, 0,       0, 7, 0,  0, 1, 1, 1, 0,  1, 7, 'hBBBB};
    vecs[13] = '{0, 0, 0,       0, 0, 0,       0, 7, 0,  0, 1, 1, 0, 0,  0, 7, 'hBBBB};

    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    qry_a = 4'($urandom_range(0, 15));
    #1;
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_mem_ready", int'(mem_ready), 1);
    chk("rst_alu_ready", int'(alu_ready), 1);
    chk("rst_hazard_a", int'(hazard_a), 0);
    qry_a = 4'd0;
    #1;

    for (int i = 0; i < 14; i++) begin
      set_in(vecs[i].mv, vecs[i].md, vecs[i].mdat, vecs[i].av, vecs[i].ad, vecs[i].adat,
             vecs[i].hold, vecs[i].qa, vecs[i].qb);
      #1;
      chk($sformatf("row%0d_count", i),     int'(count),     vecs[i].cnt);
      chk($sformatf("row%0d_mem_ready", i), int'(mem_ready), vecs[i].mr);
      chk($sformatf("row%0d_alu_ready", i), int'(alu_ready), vecs[i].ar);
      chk($sformatf("row%0d_hazard_a", i),  int'(hazard_a),  vecs[i].ha);
      chk($sformatf("row%0d_hazard_b", i),  int'(hazard_b),  vecs[i].hb);
      chk($sformatf("row%0d_wr_en", i),     int'(wr_en),     vecs[i].wen);
      chk($sformatf("row%0d_wr_addr", i),   int'(wr_addr),   vecs[i].waddr);
      chk($sformatf("row%0d_wr_data", i),   int'(wr_data),   vecs[i].wdata);
      tick();
    end

    // Fill under wb_hold; pointers sit at slot 1 here so the full queue wraps.
    for (int i = 1; i <= 4; i++) begin
      set_in(0, 0, 0, 1, i, 'h1000 + i, 1, 0, 0);
      #1;
      chk($sformatf("fill%0d_alu_ready", i), int'(alu_ready), 1);
      tick();
    end
    set_in(0, 0, 0, 1, 9, 'h9999, 1, 1, 4);
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("full_count", int'(count), 4);
      chk("full_mem_ready", int'(mem_ready), 0);
      chk("full_alu_ready", int'(alu_ready), 0);
      chk("full_hazard_a", int'(hazard_a), 1);
      chk("full_hazard_b", int'(hazard_b), 1);
      chk("full_wr_en", int'(wr_en), 0);
      tick();
    end
    qry_a = 4'd9;
    #1;
    chk("full_hazard_miss", int'(hazard_a), 0);
    wb_hold = 1'b0;
    #1;
    chk("release_alu_ready", int'(alu_ready), 0);
    tick();
    begin
      int exp_addr[5] = '{1, 2, 3, 4, 9};
      int exp_cnt[5]  = '{3, 3, 2, 1, 0};
      for (int k = 0; k < 5; k++) begin
        if (k == 0) chk("drain_alu_ready", int'(alu_ready), 1);
        chk($sformatf("drain%0d_wr_en", k), int'(wr_en), 1);
        chk($sformatf("drain%0d_wr_addr", k), int'(wr_addr), exp_addr[k]);
        chk($sformatf("drain%0d_wr_data", k), int'(wr_data),
            (k < 4) ? ('h1000 + exp_addr[k]) : 'h9999);
        chk($sformatf("drain%0d_count", k), int'(count), exp_cnt[k]);
        tick();
        alu_valid = 1'b0;
      end
    end
    #1;
    chk("drain_end_wr_en", int'(wr_en), 0);

    // Reset mid-operation with three queued entries and a pending write.
    for (int i = 10; i <= 13; i++) begin
      set_in(0, 0, 0, 1, i, 'h5000 + i, 1, 0, 0);
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 11, 10);
    tick();
    chk("pre_rst_count", int'(count), 3);
    chk("pre_rst_wr_en", int'(wr_en), 1);
    chk("pre_rst_wr_addr", int'(wr_addr), 10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("mid_rst_wr_en", int'(wr_en), 0);
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_hazard_a", int'(hazard_a), 0);
    chk("mid_rst_hazard_b", int'(hazard_b), 0);
    chk("mid_rst_wr_addr", int'(wr_addr), 0);
    chk("mid_rst_wr_data", int'(wr_data), 0);
    chk("mid_rst_alu_ready", int'(alu_ready), 1);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("post_rst%0d_wr_en", k), int'(wr_en), 0);
      chk($sformatf("post_rst%0d_count", k), int'(count), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
